// File: rtl/fir_decim.sv
// Integrate-and-dump decimator: averages each block of 2^DECIM_LOG2 samples and
// offers one truncated mean per block through a single-entry ready/valid register.
module fir_decim #(
  parameter int IN_W       = 10,
  parameter int DECIM_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_en,
  input  logic [IN_W-1:0] in0,
  output logic [IN_W-1:0] out0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ovf
);

  localparam int N     = 1 << DECIM_LOG2;
  localparam int ACC_W = IN_W + DECIM_LOG2;

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]       out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic [IN_W-1:0]  res;
  logic             dump;

  always_comb begin
    sum  = acc_q + ACC_W'(in0);
    // Top IN_W bits of the block sum are the truncated mean.
    res  = sum[ACC_W-1:DECIM_LOG2];
    dump = in_en && (cnt_q == DECIM_LOG2'(N - 1));

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (in_en) begin
      if (dump) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + DECIM_LOG2'(1);
      end
    end

    if (dump) begin
      // A consume on the same edge frees the slot, so the new result loads with no bubble.
      if (!valid_q || out_ready) begin
        out_d   = res;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out0      = out_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim: vector table, hand-written corner sequences,
// and randomized traffic compared against a block-averaging reference model.
module tb_fir_decim;

  localparam int IN_W = 10;
  localparam int DL2  = 2;
  localparam int N    = 1 << DL2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_en = 1'b0;
  logic [IN_W-1:0] in0 = '0;
  logic            out_ready = 1'b0;
  logic [IN_W-1:0] out0;
  logic            out_valid;
  logic            ovf;

  fir_decim #(.IN_W(IN_W), .DECIM_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in0(in0),
    .out0(out0), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: list of samples in the open block plus the output slot.
  int blk[$];
  int m_out   = 0;
  bit m_valid = 0;
  bit m_ovf   = 0;

  typedef struct {
    logic            en;
    logic [IN_W-1:0] x;
    logic            rdy;
    logic [IN_W-1:0] eo;
    logic            ev;
    logic            eovf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int eo, input int ev, input int eovf);
    chk({tag, ".out0"}, int'(out0), eo);
    chk({tag, ".out_valid"}, int'(out_valid), ev);
    chk({tag, ".ovf"}, int'(ovf), eovf);
  endtask

  task automatic model_step(input bit en, input int x, input bit rdy);
    bit dumped = 0;
    if (en) begin
      blk.push_back(x);
      if (blk.size() == N) begin
        int s = 0;
        foreach (blk[i]) s += blk[i];
        blk.delete();
        dumped = 1;
        if (!m_valid || rdy) begin
          m_out   = s / N;
          m_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (!dumped && m_valid && rdy) m_valid = 0;
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit en, input int x, input bit rdy);
    in_en     = en;
    in0       = IN_W'(x);
    out_ready = rdy;
    model_step(en, x, rdy);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk_all({tag, ".rst"}, 0, 0, 0);
    #2 rst = 1'b1;
    blk.delete();
    m_out = 0; m_valid = 0; m_ovf = 0;
    $display("reset %s: out0=%0d valid=%0d ovf=%0d", tag, out0, out_valid, ovf);
  endtask

  function automatic vec_t mk(bit en, int x, bit rdy, int eo, bit ev, bit eovf);
    vec_t v;
    v.en = en; v.x = IN_W'(x); v.rdy = rdy;
    v.eo = IN_W'(eo); v.ev = ev; v.eovf = eovf;
    return v;
  endfunction

  initial begin
    // Basic mean, full-scale inputs, truncation.
    tbl[0]  = mk(1, 10,   1, 0,    0, 0);
    tbl[1]  = mk(1, 20,   1, 0,    0, 0);
    tbl[2]  = mk(1, 30,   1, 0,    0, 0);
    tbl[3]  = mk(1, 40,   1, 25,   1, 0);
    tbl[4]  = mk(1, 1023, 1, 25,   0, 0);
    tbl[5]  = mk(1, 1023, 1, 25,   0, 0);
    tbl[6]  = mk(1, 1023, 1, 25,   0, 0);
    tbl[7]  = mk(1, 1023, 1, 1023, 1, 0);
    tbl[8]  = mk(1, 1,    1, 1023, 0, 0);
    tbl[9]  = mk(1, 1,    1, 1023, 0, 0);
    tbl[10] = mk(1, 1,    1, 1023, 0, 0);
    tbl[11] = mk(1, 2,    1, 1,    1, 0);
    tbl[12] = mk(0, 0,    1, 1,    0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_state", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].en, int'(tbl[i].x), tbl[i].rdy);
      $display("vec %0d: en=%0d x=%0d rdy=%0d -> out0=%0d valid=%0d ovf=%0d",
               i, tbl[i].en, tbl[i].x, tbl[i].rdy, out0, out_valid, ovf);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].eo), int'(tbl[i].ev), int'(tbl[i].eovf));
    end

    // Backpressure across two blocks: second result is dropped.
    for (int i = 0; i < 4; i++) cyc(1, 10, 0);
    chk_all("bp_first", 10, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 50, 0);
    chk_all("bp_drop", 10, 1, 1);
    cyc(0, 0, 1);
    chk_all("bp_release", 10, 0, 1);
    $display("backpressure: out0=%0d valid=%0d ovf=%0d", out0, out_valid, ovf);

    // Reset mid-block discards the partial sum.
    cyc(1, 100, 0);
    cyc(1, 100, 0);
    async_reset("midblock");
    for (int i = 0; i < 4; i++) cyc(1, 8, 1);
    chk_all("after_reset", 8, 1, 0);

    // Simultaneous consume and dump with a held result.
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 4, 0);
    chk_all("hold4", 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8, 0);
      chk_all($sformatf("hold4_b%0d", i), 4, 1, 0);
    end
    cyc(1, 8, 1);
    chk_all("consume_dump", 8, 1, 0);
    $display("consume+dump: out0=%0d valid=%0d ovf=%0d", out0, out_valid, ovf);

    // Gating: disabled samples are ignored.
    cyc(1, 4, 1);   cyc(0, 999, 1);
    cyc(1, 8, 1);   cyc(0, 999, 1);
    cyc(1, 12, 1);  cyc(0, 999, 1);
    chk_all("gate_pre", 8, 0, 0);
    cyc(1, 16, 1);
    chk_all("gating", 10, 1, 0);
    $display("gating: out0=%0d valid=%0d ovf=%0d", out0, out_valid, ovf);

    // Randomized traffic against the reference model.
    async_reset("random");
    for (int i = 0; i < 400; i++) begin
      bit en  = ($urandom % 4) != 0;
      int x   = int'($urandom_range(0, 1023));
      bit rdy = ($urandom % 3) != 0;
      cyc(en, x, rdy);
      $display("rnd %0d: en=%0d x=%0d rdy=%0d -> out0=%0d valid=%0d ovf=%0d",
               i, en, x, rdy, out0, out_valid, ovf);
      chk_all($sformatf("rnd%0d", i), m_out, int'(m_valid), int'(m_ovf));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fir_decim.md
# fir_decim

Integrate-and-dump decimator placed directly downstream of the `fir` filter. It consumes the filter's 10-bit unsigned output stream, one sample per enabled cycle. It averages each block of 2^DECIM_LOG2 consecutive samples and presents one averaged result per block through a single-entry ready/valid output register. It reduces the sample rate feeding later ALS analysis stages, and flags any result lost to consumer backpressure.

## Interface
- `IN_W`, default 10: input sample width; matches `fir` `out0`.
- `DECIM_LOG2`, default 2: log2 of the decimation factor N; N = 4 by default; legal range 1..6.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_en`  in  1: sample-accept strobe; tie high for one sample per cycle.
- `in0`  in  IN_W: unsigned sample; sampled only when `in_en`=1.
- `out0`  out  IN_W: averaged result; held stable while `out_valid`=1 and `out_ready`=0.
- `out_valid`  out  1: `out0` holds an unconsumed result.
- `out_ready`  in  1: consumer accepts `out0` on a cycle with `out_valid`=1 and `out_ready`=1.
- `ovf`  out  1: sticky; set when a completed result is dropped; cleared only by reset.

## Operation
- Internal state:
  - accumulator `acc`, width IN_W+DECIM_LOG2, which cannot overflow;
  - sample counter `cnt`, width DECIM_LOG2, counting 0..N-1;
  - output register plus its valid bit.
- Counter as FSM: `cnt`=k means k samples of the current block are accumulated. Transitions occur only on `in_en`=1. If `cnt`<N-1: `cnt`+1, `acc` += `in0`. If `cnt`=N-1 (dump): `cnt` wraps to 0 and `acc` clears to 0.
- Dump result: res = (`acc` + `in0`) >> DECIM_LOG2, a truncating unsigned mean; the result always fits in IN_W.
- Output register update on a dump cycle:
  - If `out_valid`=0, or `out_ready`=1 on the same cycle, load res and set `out_valid`=1.
  - Otherwise keep the old `out0`, discard res, and set `ovf`=1.
- Non-dump cycle with `out_valid`=1 and `out_ready`=1: `out_valid` clears; `out0` keeps its last value.
- `in_en`=0: `acc` and `cnt` hold; the output handshake still operates.
- Reset, asynchronous active-low, mid-block or at any time: the partial sum is discarded. No partial result is emitted.

## Timing
- Reset values: `out0`=0, `out_valid`=0, `ovf`=0, `acc`=0, `cnt`=0.
- Latency: `out_valid` rises and `out0` shows the result on the clock edge that samples the Nth `in0` of the block, so they are visible in the following cycle.
- Throughput: one result per N accepted samples. With `in_en` held high and `out_ready` high, `out_valid` pulses for 1 cycle every N cycles.
- Simultaneous consume and dump: the new result replaces the consumed one with no bubble; `out_valid` stays 1 and `ovf` is unchanged.
- `out_ready` has no effect while `out_valid`=0.
- `ovf` rises on the edge of the dropping dump and then stays high.
- No combinational path from `out_ready` or `in0` to any output.

## Test plan
- **Basic mean:** N=4, `in_en`=1, `out_ready`=1, inputs 10,20,30,40 → the cycle after 40 is sampled, `out0`=25 and `out_valid`=1 for exactly 1 cycle; `ovf`=0.
- **Width and truncation:**
  - four samples of 1023 → `out0`=1023, no wrap;
  - inputs 1,1,1,2 → `out0`=1 (5>>2).
- **Backpressure and drop:**
  - hold `out_ready`=0 over two blocks, 10×4 then 50×4 → `out0`=10 stays valid and `ovf`=1 after the second block;
  - raise `out_ready` → `out_valid` falls the next cycle with `out0` still 10.
- **Simultaneous consume and dump:** `out_ready`=1 on the same cycle the second block (8×4) completes after a held result of 4 → `out0`=8, `out_valid` stays 1 continuously, `ovf`=0.
- **Gating:** inputs 4,x,8,x,12,x,16 with `in_en`=1,0,1,0,1,0,1, where x=999 → `out0`=10; the x samples are ignored.
- **Reset mid-block:**
  - after two samples of 100, pulse `rst`=0 asynchronously between edges → all outputs 0 immediately;
  - then 8,8,8,8 → `out0`=8.
